// File: rtl/bcd_scan_display.sv
// bcd_scan_display
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// feeding a time-multiplexed, active-low seven-segment display.
// The display registers hold the last finished result, so a conversion in
// progress never disturbs what is shown.
// Optional feature macro: BCD_SCAN_LZ_BLANK_EN (leading-zero blanking).
// When it is undefined, every digit is shown, including leading zeros.

module bcd_scan_display #(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 3,
   parameter int REFRESH_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  bin_in,
   input  logic              start,
   output logic              ready,
   output logic              overflow,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an
);

   localparam int SCR_W = DIGITS * 4;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Largest value representable in DIGITS decimal digits (10^DIGITS - 1).
   function automatic logic [31:0] max_val_f(input int d);
      logic [31:0] p;
      p = 32'd1;
      for (int i = 0; i < d; i++) begin
         p = p * 32'd10;
      end
      return p - 32'd1;
   endfunction

   localparam logic [31:0] MAX_VAL = max_val_f(DIGITS);

   // Adds 3 to every nibble that is 5 or more (the double-dabble correction).
   function automatic logic [SCR_W-1:0] add3_all(input logic [SCR_W-1:0] s);
      logic [SCR_W-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? (s[i*4 +: 4] + 4'd3) : s[i*4 +: 4];
      end
      return r;
   endfunction

   // Active-low glyph for one hex nibble, segments ordered {g,f,e,d,c,b,a}.
   function automatic logic [6:0] glyph_f(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0:    g = 7'b1000000;
         4'h1:    g = 7'b1111001;
         4'h2:    g = 7'b0100100;
         4'h3:    g = 7'b0110000;
         4'h4:    g = 7'b0011001;
         4'h5:    g = 7'b0010010;
         4'h6:    g = 7'b0000010;
         4'h7:    g = 7'b1111000;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0010000;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b0000011;
         4'hC:    g = 7'b1000110;
         4'hD:    g = 7'b0100001;
         4'hE:    g = 7'b0000110;
         4'hF:    g = 7'b0001110;
         default: g = SEG_BLANK;
      endcase
      return g;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_LATCH   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [SCR_W-1:0]   scratch_q, scratch_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               ovf_pend_q, ovf_pend_d;
   logic [SCR_W-1:0]   disp_q, disp_d;
   logic               overflow_q, overflow_d;
   logic               ready_q, ready_d;
   logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
   logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
   logic [6:0]         seg_q, seg_d;
   logic [DIGITS-1:0]  an_q, an_d;

   logic               load_s;
   logic               shift_en_s;
   logic               latch_en_s;
   logic               last_bit_s;
   logic               ovf_in_s;
   logic [SCR_W-1:0]   scr_adj_s;
   logic [3:0]         nib_s;
   logic               blank_s;
   logic               ref_wrap_s;

   assign last_bit_s = (bit_cnt_q == CNT_W'(WIDTH - 1));
   assign ovf_in_s   = ({{(32-WIDTH){1'b0}}, bin_in} > MAX_VAL);
   assign scr_adj_s  = add3_all(scratch_q);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic: IDLE -> CONVERT (WIDTH cycles) -> LATCH (1 cycle).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CONVERT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CONVERT: begin
            if (last_bit_s) begin
               state_d = ST_LATCH;
            end else begin
               state_d = ST_CONVERT;
            end
         end
         ST_LATCH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: datapath strobes and the next value of ready.
   always_comb begin
      load_s     = 1'b0;
      shift_en_s = 1'b0;
      latch_en_s = 1'b0;
      case (state_q)
         ST_IDLE:    load_s     = start;
         ST_CONVERT: shift_en_s = 1'b1;
         ST_LATCH:   latch_en_s = 1'b1;
         default: begin
            load_s     = 1'b0;
            shift_en_s = 1'b0;
            latch_en_s = 1'b0;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   // Conversion datapath: capture, add-3 then shift, and result latch.
   always_comb begin
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      bit_cnt_d  = bit_cnt_q;
      ovf_pend_d = ovf_pend_q;
      disp_d     = disp_q;
      overflow_d = overflow_q;
      if (load_s) begin
         shift_d    = bin_in;
         scratch_d  = {SCR_W{1'b0}};
         bit_cnt_d  = {CNT_W{1'b0}};
         ovf_pend_d = ovf_in_s;
      end else if (shift_en_s) begin
         // The bit shifted out of the top nibble is dropped; overflow covers it.
         {scratch_d, shift_d} = {scr_adj_s, shift_q} << 1;
         bit_cnt_d            = bit_cnt_q + CNT_W'(1);
      end else if (latch_en_s) begin
         disp_d     = scratch_q;
         overflow_d = ovf_pend_q;
      end else begin
         disp_d     = disp_q;
         overflow_d = overflow_q;
      end
   end

   // Conversion and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q    <= {WIDTH{1'b0}};
         scratch_q  <= {SCR_W{1'b0}};
         bit_cnt_q  <= {CNT_W{1'b0}};
         ovf_pend_q <= 1'b0;
         disp_q     <= {SCR_W{1'b0}};
         overflow_q <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         shift_q    <= shift_d;
         scratch_q  <= scratch_d;
         bit_cnt_q  <= bit_cnt_d;
         ovf_pend_q <= ovf_pend_d;
         disp_q     <= disp_d;
         overflow_q <= overflow_d;
         ready_q    <= ready_d;
      end
   end

   // Refresh divider and scan index; the index moves on each divider wrap.
   always_comb begin
      ref_wrap_s = (ref_cnt_q == REF_W'(REFRESH_DIV - 1));
      if (ref_wrap_s) begin
         ref_cnt_d = {REF_W{1'b0}};
         if (scan_idx_q == IDX_W'(DIGITS - 1)) begin
            scan_idx_d = {IDX_W{1'b0}};
         end else begin
            scan_idx_d = scan_idx_q + IDX_W'(1);
         end
      end else begin
         ref_cnt_d  = ref_cnt_q + REF_W'(1);
         scan_idx_d = scan_idx_q;
      end
   end

   // Glyph selection for the digit being scanned (dash on overflow).
   always_comb begin
      nib_s   = 4'd0;
      blank_s = 1'b0;
`ifdef BCD_SCAN_LZ_BLANK_EN
      begin : lz_scan
         logic seen;
         seen = 1'b0;
         // Walk from the top digit down; a digit is blank until a non-zero
         // nibble has been seen at or above it. Digit 0 is never blank.
         for (int i = DIGITS - 1; i >= 0; i--) begin
            seen    = seen | (disp_q[i*4 +: 4] != 4'd0);
            nib_s   = nib_s | ((scan_idx_q == IDX_W'(i)) ? disp_q[i*4 +: 4] : 4'd0);
            blank_s = blank_s | ((scan_idx_q == IDX_W'(i)) && (i != 0) && !seen);
         end
      end
`else
      for (int i = 0; i < DIGITS; i++) begin
         nib_s = nib_s | ((scan_idx_q == IDX_W'(i)) ? disp_q[i*4 +: 4] : 4'd0);
      end
`endif
      if (overflow_q) begin
         seg_d = SEG_DASH;
      end else if (blank_s) begin
         seg_d = SEG_BLANK;
      end else begin
         seg_d = glyph_f(nib_s);
      end
      an_d = ~(DIGITS'(1) << scan_idx_q);
   end

   // Scan registers: enable and glyph are updated on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt_q  <= {REF_W{1'b0}};
         scan_idx_q <= {IDX_W{1'b0}};
         seg_q      <= SEG_BLANK;
         an_q       <= {DIGITS{1'b1}};
      end else begin
         ref_cnt_q  <= ref_cnt_d;
         scan_idx_q <= scan_idx_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

   assign ready    = ready_q;
   assign overflow = overflow_q;
   assign seg      = seg_q;
   assign an       = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Testbench for bcd_scan_display: two instances share clock, reset and
// stimulus. Instance A: WIDTH=8, DIGITS=3, REFRESH_DIV=4.
// Instance B: WIDTH=8, DIGITS=2, REFRESH_DIV=3 (exercises overflow).
// Expected digits come from decimal division of the value, the expected
// scan position from the number of clocks since reset release.

module tb_bcd_scan_display;

   logic       clk;
   logic       rst;
   logic [7:0] bin_in;
   logic       start;

   logic       ready_a, ovf_a;
   logic [6:0] seg_a;
   logic [2:0] an_a;
   logic       ready_b, ovf_b;
   logic [6:0] seg_b;
   logic [1:0] an_b;

   int n_checks = 0;
   int n_errors = 0;
   int k = 0;             // clocks since last reset edge
   int latched_val = 0;   // value held by the result registers
   int shown_val = 0;     // value the segment register was built from

   logic [6:0] glyph_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

   bcd_scan_display #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) dut_a (
      .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
      .ready(ready_a), .overflow(ovf_a), .seg(seg_a), .an(an_a)
   );

   bcd_scan_display #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(3)) dut_b (
      .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
      .ready(ready_b), .overflow(ovf_b), .seg(seg_b), .an(an_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clocks since reset, the time base of the scan model.
   always @(posedge clk) begin
      if (rst) k <= 0;
      else     k <= k + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (k=%0d val=%0d)", tag, obs, exp, k, shown_val);
      end
   endtask

   // Expected glyph of digit idx of value v on a d-digit display.
   function automatic logic [6:0] exp_glyph(input int v, input int idx, input int d);
      int lim = 1;
      int pw = 1;
      for (int i = 0; i < d; i++) lim = lim * 10;
      for (int i = 0; i < idx; i++) pw = pw * 10;
      if (v >= lim) return 7'b0111111;
`ifdef BCD_SCAN_LZ_BLANK_EN
      if (idx > 0 && v < pw) return 7'h7F;
`endif
      return glyph_tab[(v / pw) % 10];
   endfunction

   task automatic sample(input bit exp_rdy);
      int ia;
      int ib;
      logic [2:0] ea;
      logic [1:0] eb;
      chk("ready_a", ready_a, exp_rdy);
      chk("ready_b", ready_b, exp_rdy);
      chk("ovf_a", ovf_a, latched_val > 999);
      chk("ovf_b", ovf_b, latched_val > 99);
      if (k == 0) begin
         chk("rst_an_a", an_a, 3'b111);
         chk("rst_seg_a", seg_a, 7'h7F);
         chk("rst_an_b", an_b, 2'b11);
         chk("rst_seg_b", seg_b, 7'h7F);
      end else begin
         ia = ((k - 1) / 4) % 3;
         ib = ((k - 1) / 3) % 2;
         ea = 3'b111;
         ea[ia] = 1'b0;
         eb = 2'b11;
         eb[ib] = 1'b0;
         chk("an_a", an_a, ea);
         chk("seg_a", seg_a, exp_glyph(shown_val, ia, 3));
         chk("an_b", an_b, eb);
         chk("seg_b", seg_b, exp_glyph(shown_val, ib, 2));
      end
   endtask

   task automatic scan_idle(input int n);
      for (int i = 0; i < n; i++) begin
         sample(1'b1);
         @(negedge clk);
      end
   endtask

   // One conversion; optionally pokes start with bin_in=7 while busy.
   task automatic convert(input int v, input bit poke);
      bin_in = 8'(v);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      bin_in = 8'($urandom);
      for (int j = 0; j <= 9; j++) begin
         if (j == 9) latched_val = v;
         sample(j == 9);
         if (poke && j == 1) begin
            start  = 1'b1;
            bin_in = 8'd7;
         end else begin
            start  = 1'b0;
         end
         @(negedge clk);
      end
      shown_val = latched_val;
   endtask

   // Starts a conversion, then resets in the middle of it.
   task automatic reset_mid(input int v);
      bin_in = 8'(v);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      for (int j = 0; j < 3; j++) begin
         sample(1'b0);
         @(negedge clk);
      end
      rst = 1'b1;
      latched_val = 0;
      shown_val   = 0;
      @(negedge clk);
      sample(1'b1);
      @(negedge clk);
      sample(1'b1);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      bin_in = 8'd0;
      @(negedge clk);
      sample(1'b1);
      @(negedge clk);
      sample(1'b1);
      rst = 1'b0;
      @(negedge clk);
      scan_idle(24);

      convert(255, 1'b0);  scan_idle(24);
      convert(100, 1'b0);  scan_idle(12);
      convert(42, 1'b0);   scan_idle(12);
      convert(99, 1'b0);   scan_idle(12);
      convert(255, 1'b1);  scan_idle(12);
      convert(7, 1'b0);    scan_idle(24);
      convert(0, 1'b0);    scan_idle(12);
      convert(123, 1'b0);  scan_idle(5);
      reset_mid(200);      scan_idle(24);

      for (int r = 0; r < 12; r++) begin
         convert(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         scan_idle(int'($urandom_range(1, 14)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
